// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   sbEntry_t : one scoreboard entry {valid, isLoad, dst}; dst is sized for the
//               widest supported register address and zero-extended on use.
//   FWD_RF    : fwd_sel code meaning "take the operand from the register file".
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int SB_AW_MAX = 8;
    localparam int FWD_RF    = 0;

    typedef struct packed {
        logic                 valid;
        logic                 isLoad;
        logic [SB_AW_MAX-1:0] dst;
    } sbEntry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Decode-side and control-side signals of the hazard controller.
//   master : the pipeline (drives decode info and branch resolution)
//   slave  : the hazard controller (drives stall, flushes, forwarding selects)
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int NRD    = 2,
    parameter int CNT_W  = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic                         id_valid;
    logic [NRD-1:0][REG_AW-1:0]   id_src;
    logic [NRD-1:0]               id_src_used;
    logic [REG_AW-1:0]            id_dst;
    logic                         id_wr;
    logic                         id_load;
    logic                         ex_br_taken;

    logic                         stall;
    logic                         flush_if_id;
    logic                         flush_id_ex;
    logic [NRD-1:0][SW-1:0]       fwd_sel;
    logic [CNT_W-1:0]             stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_dst, id_wr, id_load, ex_br_taken,
        input  stall, flush_if_id, flush_id_ex, fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dst, id_wr, id_load, ex_br_taken,
        output stall, flush_if_id, flush_id_ex, fwd_sel, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// For one decode source operand, finds the youngest in-flight stage that will
// write the same register and reports whether that producer is a load.
//   srcReg    : source register number
//   srcUsed   : operand is actually read
//   entries   : scoreboard, entry s mirrors pipeline stage s
//   fwdSel    : youngest matching stage, FWD_RF when none
//   youngLoad : the youngest matching producer is a load
// -----------------------------------------------------------------------------
module hazard_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SW     = 2
) (
    input  logic [REG_AW-1:0]   srcReg,
    input  logic                srcUsed,
    input  sbEntry_t [DEPTH:1]  entries,
    output logic [SW-1:0]       fwdSel,
    output logic                youngLoad
);

    logic [SB_AW_MAX-1:0] srcWide;

    always_comb begin
        srcWide            = '0;
        srcWide[REG_AW-1:0] = srcReg;
        fwdSel             = SW'(FWD_RF);
        youngLoad          = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites the rest.
        for (int s = DEPTH; s >= 1; s--) begin
            if (srcUsed && (srcReg != '0) && entries[s].valid &&
                (entries[s].dst == srcWide)) begin
                fwdSel    = SW'(s);
                youngLoad = entries[s].isLoad;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Load-use stall, branch flush and forwarding-select controller for an
// in-order pipeline. A shift-register scoreboard mirrors the destination of
// every instruction in stages 1..DEPTH after decode.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of pipe_hazard_ctrl_if (decode info in; stall, flushes,
//          fwd_sel, stall_cnt out)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int NRD        = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam int SW = $clog2(DEPTH + 1);

    sbEntry_t [DEPTH:1]       sb;
    sbEntry_t                 newEntry;
    logic [NRD-1:0][SW-1:0]   fwdSelInt;
    logic [NRD-1:0]           portYoungLoad;
    logic [NRD-1:0]           portHazard;
    logic                     stallInt;
    logic [CNT_W-1:0]         stallCnt;

    for (genvar k = 0; k < NRD; k++) begin : g_match
        hazard_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SW     (SW)
        ) u_match (
            .srcReg    (bus.id_src[k]),
            .srcUsed   (bus.id_src_used[k]),
            .entries   (sb),
            .fwdSel    (fwdSelInt[k]),
            .youngLoad (portYoungLoad[k])
        );
    end

    always_comb begin
        portHazard = '0;
        // Load data is not available until the producer reaches LOAD_STAGE.
        for (int k = 0; k < NRD; k++) begin
            portHazard[k] = portYoungLoad[k] && (fwdSelInt[k] < SW'(LOAD_STAGE));
        end
        // rst gating keeps outputs quiet while reset is held, whatever the inputs.
        stallInt = rst && bus.id_valid && (|portHazard) && !bus.ex_br_taken;
    end

    always_comb begin
        newEntry                   = '0;
        newEntry.dst[REG_AW-1:0]   = bus.id_dst;
        newEntry.isLoad            = bus.id_load;
        newEntry.valid             = bus.id_valid && bus.id_wr && (bus.id_dst != '0);
        if (stallInt || bus.ex_br_taken) begin
            newEntry = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb       <= '0;
            stallCnt <= '0;
        end else begin
            sb[1] <= newEntry;
            // Older stages shift unconditionally; a branch only squashes stage 1.
            for (int s = 2; s <= DEPTH; s++) begin
                sb[s] <= sb[s-1];
            end
            if (stallInt && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall       = stallInt;
    assign bus.flush_if_id = rst && bus.ex_br_taken;
    assign bus.flush_id_ex = rst && (bus.ex_br_taken || stallInt);
    assign bus.fwd_sel     = fwdSelInt;
    assign bus.stall_cnt   = stallCnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width; register 0 is hard-wired zero.
REQ-002 Parameter DEPTH, default 3: in-flight stages tracked after decode (1=EX, 2=MEM, 3=WB); range 2..6.
REQ-003 Parameter NRD, default 2: decode source-operand ports; range 1..4.
REQ-004 Parameter LOAD_STAGE, default 2: first stage whose output carries load data; range 1..DEPTH.
REQ-005 Parameter CNT_W, default 16: stall-counter width.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 id_valid  input  1  decode holds a real instruction.
REQ-009 id_src  input  NRD x REG_AW  decode source register numbers.
REQ-010 id_src_used  input  NRD  source k is actually read.
REQ-011 id_dst  input  REG_AW  decode destination register.
REQ-012 id_wr  input  1  decode instruction writes id_dst.
REQ-013 id_load  input  1  decode instruction is a load.
REQ-014 ex_br_taken  input  1  branch resolved taken in stage 1 this cycle.
REQ-015 stall  output  1  hold PC and IF/ID, insert bubble into stage 1.
REQ-016 flush_if_id  output  1  clear IF/ID register.
REQ-017 flush_id_ex  output  1  clear ID/EX register.
REQ-018 fwd_sel  output  NRD x clog2(DEPTH+1)  per source: 0 = register file, s = stage-s result.
REQ-019 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-020 Scoreboard SHALL hold DEPTH entries {valid, dst, is_load}, entry s mirroring stage s; shifts s->s+1 every clock, entry DEPTH discarded.
REQ-021 Entry 1 SHALL load {id_valid & id_wr & (id_dst!=0), id_dst, id_load} when neither stall nor ex_br_taken; otherwise valid=0 (bubble).
REQ-022 Match(k,s) SHALL be id_src_used[k] & id_src[k]!=0 & entry s valid & entry s dst==id_src[k].
REQ-023 fwd_sel[k] SHALL be the smallest s with Match(k,s) (youngest wins), else 0; combinational from current state and inputs.
REQ-024 stall SHALL assert when id_valid and, for any k, youngest match s has is_load and s<LOAD_STAGE.
REQ-025 ex_br_taken SHALL force stall=0 and assert flush_if_id and flush_id_ex in the same cycle.
REQ-026 Without ex_br_taken, flush_if_id=0; flush_id_ex SHALL equal stall.
REQ-027 A load-use stall SHALL last exactly LOAD_STAGE-s cycles, then clear as the producer reaches LOAD_STAGE.
REQ-028 Entries in stages >=2 SHALL not be squashed by ex_br_taken (they are older than the branch).
REQ-029 stall_cnt SHALL increment on every clock where stall=1 and saturate at all-ones.
REQ-030 Outputs SHALL depend only on current state and inputs; no combinational path from stall back into Match.

Reset
REQ-031 rst low SHALL clear all entry valid bits and stall_cnt to 0 immediately, independent of clk.
REQ-032 During reset, stall=0, flush_if_id=0, flush_id_ex=0, fwd_sel=0.
REQ-033 First clock after rst rises SHALL capture entry 1 normally; no stale hazard survives reset mid-stall.

Structure
REQ-034 Shared package SHALL hold the scoreboard entry struct and fwd_sel encoding constant FWD_RF=0.
REQ-035 One sub-module, hazard_match, SHALL compute per-port youngest match and load flag; instantiated NRD times.

Verification
REQ-036 EX->dependent: add r3 then add r4,r3,r1 -> fwd_sel[0]=1, stall=0.
REQ-037 Load-use: lw r5 then add r6,r5,r5 (defaults) -> stall=1 one cycle, flush_id_ex=1, then fwd_sel[0]=fwd_sel[1]=2, stall_cnt=1.
REQ-038 Double write: r7 written in stages 1 and 2 simultaneously -> fwd_sel=1 for a reader of r7.
REQ-039 Register zero: id_src=0 with entry dst=0 attempted -> fwd_sel=0, stall=0.
REQ-040 Branch during load-use stall: ex_br_taken=1 -> stall=0, flush_if_id=1, flush_id_ex=1, entry 1 bubble next cycle.
REQ-041 Reset mid-stall: rst low while stall=1 -> all outputs 0 immediately; stall_cnt=0; with CNT_W=2, four stall cycles -> stall_cnt=3.
